// File: rtl/buzz_pkg.sv
// Shared constants for the Pong audio/timebase block: clock rate, tone words
// and the default time-stamp divider.
package buzz_pkg;

    localparam int unsigned CLK_HZ       = 100_000_000;
    localparam int unsigned HALF_W_DEF   = 22;
    localparam int unsigned TS_W_DEF     = 4;
    localparam int unsigned TICK_DIV_DEF = CLK_HZ;

    // 400 Hz hit tone: 100 MHz / (2 * 125000)
    localparam logic [21:0] TONE_HIT = 22'd125000;
    localparam logic [21:0] TONE_OFF = 22'd0;

    // Prescaler width for a given divider; never narrower than one bit.
    function automatic int unsigned pre_width(input int unsigned div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/stamp_divider.sv
// Slow free-running time stamp: advances once every TICK_DIV clk cycles and
// wraps modulo 2^TS_W.
module stamp_divider
    import buzz_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int unsigned TS_W     = TS_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic [TS_W-1:0] time_stamp
);

    localparam int unsigned      PRE_W    = pre_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] prescaler;
    logic [PRE_W-1:0] prescaler_next;
    logic [TS_W-1:0]  time_stamp_next;

    always_comb begin
        prescaler_next  = prescaler + PRE_W'(1);
        time_stamp_next = time_stamp;
        if (prescaler == PRE_LAST) begin
            prescaler_next  = '0;
            time_stamp_next = time_stamp + TS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler  <= '0;
            time_stamp <= '0;
        end else begin
            prescaler  <= prescaler_next;
            time_stamp <= time_stamp_next;
        end
    end

endmodule

// File: rtl/buzz_tone_gen.sv
// Pong buzzer: square wave with a half-period of `counter` clk cycles (0 = silent),
// plus a slow free-running time stamp.
module buzz_tone_gen
    import buzz_pkg::*;
#(
    parameter int unsigned HALF_W   = HALF_W_DEF,
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int unsigned TS_W     = TS_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HALF_W-1:0] counter,
    output logic              sound,
    output logic [TS_W-1:0]   time_stamp
);

    logic [HALF_W-1:0] tcnt;
    logic [HALF_W-1:0] tcnt_next;
    logic              sound_next;

    // The >= compare lets a lowered counter end the half-period at once
    // instead of letting tcnt run on and wrap.
    always_comb begin
        tcnt_next  = tcnt + HALF_W'(1);
        sound_next = sound;
        if (counter == '0) begin
            tcnt_next  = '0;
            sound_next = 1'b0;
        end else if (tcnt >= counter - HALF_W'(1)) begin
            tcnt_next  = '0;
            sound_next = ~sound;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt  <= '0;
            sound <= 1'b0;
        end else begin
            tcnt  <= tcnt_next;
            sound <= sound_next;
        end
    end

    stamp_divider #(
        .TICK_DIV (TICK_DIV),
        .TS_W     (TS_W)
    ) u_stamp_divider (
        .clk        (clk),
        .reset      (reset),
        .time_stamp (time_stamp)
    );

endmodule

// File: tb/tb_buzz_tone_gen.sv
// Self-checking bench for buzz_tone_gen with a 10-cycle timebase; expected
// values come from closed-form tone/stamp formulas counted from reset or silence.
module tb_buzz_tone_gen;

    localparam int unsigned HALF_W = 22;
    localparam int unsigned TICK   = 10;
    localparam int unsigned TS_W   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [HALF_W-1:0] counter = '0;
    logic              sound;
    logic [TS_W-1:0]   time_stamp;

    int          passed = 0;
    int          total  = 0;
    int unsigned edges;

    buzz_tone_gen #(
        .HALF_W   (HALF_W),
        .TICK_DIV (TICK),
        .TS_W     (TS_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .counter    (counter),
        .sound      (sound),
        .time_stamp (time_stamp)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset was released.
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    // Reference: k edges into a steady nonzero half-period n from a clean start.
    function automatic logic exp_tone(input int unsigned k, input int unsigned n);
        return logic'((k / n) % 2);
    endfunction

    function automatic logic [TS_W-1:0] exp_ts(input int unsigned e);
        return TS_W'((e / TICK) % (1 << TS_W));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [HALF_W-1:0] c);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        counter = c;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset('0);
        total++;
        if (sound !== 1'b0) $display("FAIL reset_sound: got %0b expected 0", sound);
        else passed++;
        total++;
        if (time_stamp !== '0) $display("FAIL reset_ts: got %0d expected 0", time_stamp);
        else passed++;
        counter = 22'd1;
        repeat (15) step();
        total++;
        if (sound !== 1'b1 || time_stamp !== 4'd1)
            $display("FAIL pre_reset_state: got sound=%0b ts=%0d expected sound=1 ts=1",
                     sound, time_stamp);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (sound !== 1'b0) $display("FAIL async_reset_sound: got %0b expected 0", sound);
        else passed++;
        total++;
        if (time_stamp !== '0) $display("FAIL async_reset_ts: got %0d expected 0", time_stamp);
        else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_tone_four();
        int high = 0;
        apply_reset(22'd4);
        for (int k = 1; k <= 80; k++) begin
            step();
            total++;
            if (sound !== exp_tone(k, 4))
                $display("FAIL tone4 edge %0d: got %0b expected %0b", k, sound, exp_tone(k, 4));
            else passed++;
            high += int'(sound);
        end
        total++;
        if (high != 40) $display("FAIL tone4_duty: got %0d high cycles expected 40", high);
        else passed++;
    endtask

    task automatic test_silent_then_three();
        apply_reset('0);
        for (int k = 1; k <= 50; k++) begin
            step();
            total++;
            if (sound !== 1'b0) $display("FAIL silent edge %0d: got %0b expected 0", k, sound);
            else passed++;
        end
        counter = 22'd3;
        for (int k = 1; k <= 12; k++) begin
            step();
            total++;
            if (sound !== exp_tone(k, 3))
                $display("FAIL tone3 edge %0d: got %0b expected %0b", k, sound, exp_tone(k, 3));
            else passed++;
            total++;
            if (time_stamp !== exp_ts(edges))
                $display("FAIL tone3_ts edge %0d: got %0d expected %0d", k, time_stamp,
                         exp_ts(edges));
            else passed++;
        end
    endtask

    task automatic test_lower_midway();
        logic exp;
        apply_reset(22'd10);
        repeat (7) step();
        total++;
        if (sound !== 1'b0) $display("FAIL lower_pre: got %0b expected 0", sound);
        else passed++;
        counter = 22'd2;
        for (int j = 0; j <= 8; j++) begin
            step();
            exp = 1'b1 ^ logic'((j / 2) % 2);
            total++;
            if (sound !== exp) $display("FAIL lower j=%0d: got %0b expected %0b", j, sound, exp);
            else passed++;
        end
    endtask

    task automatic test_timebase();
        apply_reset('0);
        for (int e = 1; e <= 170; e++) begin
            step();
            total++;
            if (time_stamp !== exp_ts(e))
                $display("FAIL timebase edge %0d: got %0d expected %0d", e, time_stamp, exp_ts(e));
            else passed++;
        end
    endtask

    task automatic test_half_clk_then_off();
        apply_reset(22'd1);
        for (int k = 1; k <= 11; k++) begin
            step();
            total++;
            if (sound !== logic'(k % 2))
                $display("FAIL clk2 edge %0d: got %0b expected %0b", k, sound, logic'(k % 2));
            else passed++;
        end
        counter = '0;
        for (int k = 1; k <= 10; k++) begin
            step();
            total++;
            if (sound !== 1'b0) $display("FAIL off edge %0d: got %0b expected 0", k, sound);
            else passed++;
        end
    endtask

    task automatic test_random_segments();
        int unsigned n;
        int unsigned len;
        apply_reset('0);
        for (int s = 0; s < 8; s++) begin
            n       = $urandom_range(1, 12);
            len     = $urandom_range(5, 40);
            counter = HALF_W'(n);
            for (int unsigned k = 1; k <= len; k++) begin
                step();
                total++;
                if (sound !== exp_tone(k, n))
                    $display("FAIL rand seg%0d n=%0d k=%0d: got %0b expected %0b", s, n, k, sound,
                             exp_tone(k, n));
                else passed++;
                total++;
                if (time_stamp !== exp_ts(edges))
                    $display("FAIL rand_ts seg%0d k=%0d: got %0d expected %0d", s, k, time_stamp,
                             exp_ts(edges));
                else passed++;
            end
            counter = '0;
            step();
            total++;
            if (sound !== 1'b0) $display("FAIL rand_silence seg%0d: got %0b expected 0", s, sound);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_tone_four();
        test_silent_then_three();
        test_lower_midway();
        test_timebase();
        test_half_clk_then_off();
        test_random_segments();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
